// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // Number of low address bits that must be zero for a word-aligned access.
  localparam int unsigned WORD_LSB = 2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory bus bundle for mem_arbiter; slave = arbiter side, master = environment.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic              i_err;
  logic [31:0]       i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic              d_err;
  logic [31:0]       d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_wenable;
  logic              mem_renable;
  logic [31:0]       mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
           mem_addr, mem_wdata, mem_wenable, mem_renable
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
           mem_addr, mem_wdata, mem_wenable, mem_renable
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selection. MEM_ARB_RR_EN selects round-robin; otherwise data port wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic ptr,
  output logic gnt
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    if (i_req && d_req) begin
      gnt = ptr;
    end else if (d_req) begin
      gnt = REQ_D;
    end else begin
      gnt = REQ_I;
    end
  end
`else
  logic unused_in;
  assign unused_in = ptr ^ i_req;
  assign gnt = d_req ? REQ_D : REQ_I;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and load/store ports; MEM_ARB_RR_EN enables
// round-robin arbitration, otherwise the data port has fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 16,
  parameter int unsigned ADDR_W    = 32
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.slave  bus
);

  state_e            state_q, state_d;
  logic              win_q, win_d;
  logic              ptr_q, ptr_d;
  logic              err_q, err_d;
  logic              rd_q, rd_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              wen_q, wen_d;
  logic              ren_q, ren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_legal;
  logic              gnt;

  mem_arb_pick u_pick (
    .i_req (bus.i_req),
    .d_req (bus.d_req),
    .ptr   (ptr_q),
    .gnt   (gnt)
  );

  assign sel_addr  = (gnt == REQ_D) ? bus.d_addr : bus.i_addr;
  assign sel_legal = (sel_addr[WORD_LSB-1:0] == '0) && (sel_addr < ADDR_W'(MEM_BYTES));

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    ren_d   = 1'b0;
    i_ack_d = 1'b0;
    d_ack_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.i_req || bus.d_req) begin
          win_d = gnt;
          ptr_d = ~gnt;
          if (sel_legal) begin
            addr_d = sel_addr;
            if (gnt == REQ_D) wdata_d = bus.d_wdata;
            wen_d   = (gnt == REQ_D) && bus.d_we;
            ren_d   = !wen_d;
            rd_d    = ren_d;
            err_d   = 1'b0;
            state_d = StIssue;
          end else begin
            // Rejected: skip the memory cycle and acknowledge straight away.
            err_d   = 1'b1;
            rd_d    = 1'b0;
            i_ack_d = (gnt == REQ_I);
            d_ack_d = (gnt == REQ_D);
            state_d = StResp;
          end
        end
      end
      StIssue: begin
        i_ack_d = (win_q == REQ_I);
        d_ack_d = (win_q == REQ_D);
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      win_q   <= REQ_I;
      ptr_q   <= REQ_I;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      i_ack_q <= i_ack_d;
      d_ack_q <= d_ack_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.i_ack       = i_ack_q;
  assign bus.i_err       = i_ack_q & err_q;
  assign bus.i_rdata     = (i_ack_q && rd_q) ? bus.mem_rdata : '0;
  assign bus.d_ack       = d_ack_q;
  assign bus.d_err       = d_ack_q & err_q;
  assign bus.d_rdata     = (d_ack_q && rd_q) ? bus.mem_rdata : '0;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_wenable = wen_q;
  assign bus.mem_renable = ren_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, arbitration order, random traffic, reset abort.
module tb_mem_arbiter;

  localparam int unsigned MEM_BYTES = 16;
  localparam int unsigned ADDR_W    = 32;

  typedef struct {
    logic        dport;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   viol = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Registered-read memory attached to the arbiter's memory port.
  logic [31:0] phys [4] = '{default: '0};
  always @(posedge clk) begin
    if (bus.mem_wenable) phys[bus.mem_addr[3:2]] <= bus.mem_wdata;
    if (bus.mem_renable) bus.mem_rdata <= phys[bus.mem_addr[3:2]];
  end

  // Reference contents as seen by requesters.
  logic [31:0] ref_mem [4] = '{default: '0};

  always @(negedge clk) begin
    if (rst_n && ((bus.mem_wenable && bus.mem_renable) || (bus.i_ack && bus.d_ack) ||
                  (!bus.i_ack && (bus.i_rdata != 0 || bus.i_err)) ||
                  (!bus.d_ack && (bus.d_rdata != 0 || bus.d_err))))
      viol <= viol + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic is_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < MEM_BYTES);
  endfunction

  // Called just after a rising edge with the arbiter idle.
  task automatic access(input logic dport, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_err,
                        input logic [31:0] exp_rdata, input string name);
    int          lat;
    int          wen_n;
    int          ren_n;
    logic        got;
    logic        ack_err;
    logic [31:0] rdata;
    lat = 0; wen_n = 0; ren_n = 0; got = 1'b0; ack_err = 1'b0; rdata = '0;
    if (dport) begin
      bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_req = 1'b1;
    end else begin
      bus.i_addr = addr; bus.i_req = 1'b1;
    end
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.mem_wenable) wen_n++;
      if (bus.mem_renable) ren_n++;
      if (dport ? bus.d_ack : bus.i_ack) begin
        got     = 1'b1;
        ack_err = dport ? bus.d_err : bus.i_err;
        rdata   = dport ? bus.d_rdata : bus.i_rdata;
      end
    end
    @(posedge clk);
    #1;
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    check($sformatf("%s ack", name), 32'(got), 32'd1);
    // Legal: ack two cycles after the sampling edge; rejected: one cycle.
    check($sformatf("%s latency", name), 32'(lat), exp_err ? 32'd2 : 32'd3);
    check($sformatf("%s err", name), 32'(ack_err), 32'(exp_err));
    check($sformatf("%s rdata", name), rdata, exp_rdata);
    check($sformatf("%s wen", name), 32'(wen_n), 32'(!exp_err && we));
    check($sformatf("%s ren", name), 32'(ren_n), 32'(!exp_err && !we));
    if (we && !exp_err) ref_mem[addr[3:2]] = wdata;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        vecs[10];
    logic        order[4];
    int          cyc[4];
    int          n;
    int          acks;
    logic        exp_first;
    logic        rd;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        legal;

    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    vecs[0] = '{1'b1, 1'b1, 32'd4,  32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'd4,  32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b0, 32'd4,  32'h0,        1'b0, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b1, 32'd13, 32'h11111111, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 32'd16, 32'h22222222, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'd13, 32'h0,        1'b1, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 32'd2,  32'h0,        1'b1, 32'h0};
    vecs[7] = '{1'b1, 1'b1, 32'd0,  32'h12345678, 1'b0, 32'h0};
    vecs[8] = '{1'b0, 1'b0, 32'd0,  32'h0,        1'b0, 32'h12345678};
    vecs[9] = '{1'b1, 1'b0, 32'd20, 32'h0,        1'b1, 32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset flags", 32'({bus.i_ack, bus.i_err, bus.d_ack, bus.d_err,
                              bus.mem_wenable, bus.mem_renable}), 32'd0);
    check("reset i_rdata", bus.i_rdata, 32'd0);
    check("reset d_rdata", bus.d_rdata, 32'd0);
    check("reset mem_addr", bus.mem_addr, 32'd0);
    check("reset mem_wdata", bus.mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++)
      access(vecs[i].dport, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err,
             vecs[i].exp_rdata, $sformatf("vec%0d", i));

    // Both ports requesting continuously after a fresh reset.
    do_reset();
    bus.i_addr = 32'd0; bus.d_addr = 32'd8; bus.d_we = 1'b0;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    n = 0;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(negedge clk);
      if (bus.i_ack || bus.d_ack) begin
        order[n] = bus.d_ack;
        cyc[n]   = c;
        n++;
      end
    end
    @(posedge clk);
    #1;
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    check("both grants", 32'(n), 32'd4);
`ifdef MEM_ARB_RR_EN
    exp_first = 1'b0;
`else
    exp_first = 1'b1;
`endif
    for (int k = 0; k < n; k++) begin
`ifdef MEM_ARB_RR_EN
      check($sformatf("both order%0d", k), 32'(order[k]), 32'(exp_first ^ k[0]));
`else
      check($sformatf("both order%0d", k), 32'(order[k]), 32'(exp_first));
`endif
      if (k > 0) check($sformatf("both gap%0d", k), 32'(cyc[k] - cyc[k-1]), 32'd3);
    end
    @(posedge clk);
    #1;

    // Random traffic against the reference contents.
    for (int i = 0; i < 40; i++) begin
      rd    = 1'($urandom_range(0, 1));
      we    = rd ? 1'($urandom_range(0, 1)) : 1'b0;
      addr  = 32'($urandom_range(0, 23));
      wdata = $urandom;
      legal = is_legal(addr);
      access(rd, we, addr, wdata, !legal, (legal && !we) ? ref_mem[addr[3:2]] : 32'd0,
             $sformatf("rnd%0d", i));
    end

    // Reset during the memory cycle of a store aborts it.
    bus.d_we = 1'b1; bus.d_addr = 32'd8; bus.d_wdata = 32'hCAFEF00D; bus.d_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort issue wen", 32'(bus.mem_wenable), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort wen drop", 32'(bus.mem_wenable), 32'd0);
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.d_ack || bus.i_ack) acks++;
    end
    bus.d_req = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.d_ack || bus.i_ack || bus.mem_wenable) acks++;
    end
    check("abort no ack", 32'(acks), 32'd0);
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, 32'd8, 32'd0, 1'b0, ref_mem[2], "post abort load");
    access(1'b1, 1'b1, 32'd12, 32'h0BADF00D, 1'b0, 32'd0, "post abort store");
    access(1'b0, 1'b0, 32'd12, 32'd0, 1'b0, 32'h0BADF00D, "post abort fetch");

    @(negedge clk);
    check("protocol", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences and shares the single-port byte-addressed data memory between the CPU's instruction-fetch port and its load/store port. Each requester raises a level request with address (and write data for stores). The arbiter grants one requester at a time, drives the memory's write/read enables for exactly one cycle, and returns a one-cycle acknowledge with read data. Out-of-range or misaligned accesses are rejected without touching memory.

## Interface
- MEM_BYTES, 16: memory size in bytes; must be a multiple of 4.
- ADDR_W, 32: address width on all ports.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; level, held until i_ack.
- i_addr  in  ADDR_W  fetch byte address; stable while i_req.
- i_ack  out  1  one-cycle pulse ending the fetch access.
- i_err  out  1  valid with i_ack; access was rejected.
- i_rdata  out  32  fetch data; valid with i_ack, 0 otherwise.
- d_req  in  1  load/store request; level, held until d_ack.
- d_we  in  1  1 = store, 0 = load; stable while d_req.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data, big-endian (byte 0 = bits 31:24).
- d_ack, d_err, d_rdata  out  1/1/32  same as fetch-side equivalents.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  memory write data.
- mem_wenable  out  1  memory write enable.
- mem_renable  out  1  memory read enable.
- mem_rdata  in  32  memory read data; registered in memory, valid the cycle after mem_renable.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: when any request is present, pick a winner (see Configuration) and check its address.
  - Legal: addr[1:0]==0 and addr < MEM_BYTES.
  - Legal access: register mem_addr, mem_wdata, mem_wenable (= store) or mem_renable (= load/fetch), then go to ISSUE.
  - Illegal access: enables stay 0, winner's err flag is registered, then go to RESP.
- ISSUE: memory performs the access. Enables drop to 0 at the end of this cycle. Register the winner's ack and go to RESP.
- RESP: winner's ack=1, with err per check. Winner's rdata = mem_rdata for a legal load/fetch, 0 for a store or a rejected access. Always return to IDLE.
- No arbitration happens in ISSUE or RESP. A request arriving there waits.
- Requesters deassert req in the cycle after ack. A req still high in IDLE is a new request.
- mem_addr and mem_wdata hold their last value outside ISSUE. Only the enables qualify them.
- Fetch requests never write memory.

## Timing
- Reset (rst_n low, asynchronous): state IDLE; every output 0; round-robin pointer favours fetch.
- Reset mid-access aborts the access; no ack is issued.
- Legal access: req sampled at edge E0 → enable high in cycle 1 → ack in cycle 2 → IDLE in cycle 3.
- Latency is 2 cycles from the sampling edge to ack. Throughput is one access per 3 cycles.
- Rejected access: ack/err in cycle 1, since it skips ISSUE. Throughput is one per 2 cycles.
- Both requests present in IDLE: exactly one is granted. The loser is served in the next IDLE cycle.
- Enables and acks are one-hot; never two at once.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - Pointer toggles to the other requester after each grant, whether legal or rejected.
  - With both requesting continuously, grants alternate.
- MEM_ARB_RR_EN undefined: fixed priority, data port wins.
  - Fetch can starve; this is accepted.

## Structure
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE/ISSUE/RESP);
  - the requester ID constants REQ_I=0 and REQ_D=1;
  - the word-alignment constant.
- One natural sub-module: mem_arb_pick. It is combinational and takes i_req, d_req and the pointer, and returns the grant ID. Both configurations live inside it.

## Test plan
- Reset: hold rst_n low, then release. All outputs read 0; FSM in IDLE.
- Store then load on the data port:
  - store d_addr=4, d_wdata=0xDEADBEEF → mem_wenable high 1 cycle, d_ack 2 cycles after the sampling edge;
  - load d_addr=4 → d_rdata=0xDEADBEEF with d_ack, d_err=0.
- Simultaneous requests with MEM_ARB_RR_EN, fetch addr 0 and data addr 8 held high:
  - first grant goes to fetch, then data, alternating;
  - without the macro, data is always served first.
- Illegal addresses:
  - d_addr=13 (misaligned) or d_addr=16 (out of range) → d_ack and d_err in cycle 1;
  - mem_wenable and mem_renable never rise; d_rdata=0.
- Reset mid-access: drop rst_n during ISSUE of a store. No ack appears; after release, the next access completes normally.
